// File: rtl/seg_scroll_disp.sv
// Multiplexed 7-segment hex display driver with static and scrolling modes.
// Words loaded while scrolling wait in a shadow register until the lap wraps,
// so a word is never shown half old and half new.
module seg_scroll_disp #(
  parameter int DIGITS      = 4,
  parameter int DATA_W      = 32,
  parameter int REFRESH_DIV = 32000,
  parameter int SCROLL_DIV  = 2**24,
  parameter int GAP         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  input  logic              en,
  input  logic              scroll_en,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        seg,
  output logic              upd_pend,
  output logic              wrap_pulse
);

  localparam int NIB   = DATA_W / 4;
  localparam int L     = NIB + GAP;
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int POS_W = $clog2(L);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int SCR_W = $clog2(SCROLL_DIV);

  logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic [DIG_W-1:0]  digit_idx_q, digit_idx_d;
  logic [SCR_W-1:0]  scr_cnt_q, scr_cnt_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [DATA_W-1:0] disp_word_q, disp_word_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              upd_pend_q, upd_pend_d;
  logic              wrap_q, wrap_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;

  logic              ref_wrap, scr_wrap, lap_end;
  int                p, nib_i;
  logic              dash;
  logic [DATA_W-1:0] word_sh;
  logic [3:0]        nib;

  // Active-low segment pattern {a,b,c,d,e,f,g,dp} for one hex digit.
  function automatic logic [7:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 8'h03;  4'h1: hex2seg = 8'h9F;
      4'h2: hex2seg = 8'h25;  4'h3: hex2seg = 8'h0D;
      4'h4: hex2seg = 8'h99;  4'h5: hex2seg = 8'h49;
      4'h6: hex2seg = 8'h41;  4'h7: hex2seg = 8'h1F;
      4'h8: hex2seg = 8'h01;  4'h9: hex2seg = 8'h09;
      4'hA: hex2seg = 8'h11;  4'hB: hex2seg = 8'hC1;
      4'hC: hex2seg = 8'h63;  4'hD: hex2seg = 8'h85;
      4'hE: hex2seg = 8'h61;  default: hex2seg = 8'h71;
    endcase
  endfunction

  assign ref_wrap = (ref_cnt_q == REF_W'(REFRESH_DIV - 1));
  assign scr_wrap = (scr_cnt_q == SCR_W'(SCROLL_DIV - 1));
  assign lap_end  = scroll_en && scr_wrap && (pos_q == POS_W'(L - 1));

  // Refresh divider and digit scan pointer; these never depend on mode or en.
  always_comb begin
    ref_cnt_d   = ref_wrap ? '0 : ref_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (ref_wrap)
      digit_idx_d = (digit_idx_q == DIG_W'(DIGITS - 1)) ? '0 : digit_idx_q + 1'b1;
  end

  // Scroll position, word/shadow handover and the lap-wrap pulse.
  always_comb begin
    scr_cnt_d   = scr_cnt_q;
    pos_d       = pos_q;
    disp_word_d = disp_word_q;
    shadow_d    = shadow_q;
    upd_pend_d  = upd_pend_q;
    wrap_d      = 1'b0;
    if (!scroll_en) begin
      // Static: a pending shadow (left from scroll mode) commits at once.
      scr_cnt_d  = '0;
      pos_d      = '0;
      upd_pend_d = 1'b0;
      if (load)            disp_word_d = data_in;
      else if (upd_pend_q) disp_word_d = shadow_q;
    end else begin
      scr_cnt_d = scr_wrap ? '0 : scr_cnt_q + 1'b1;
      if (scr_wrap)
        pos_d = (pos_q == POS_W'(L - 1)) ? '0 : pos_q + 1'b1;
      wrap_d = lap_end;
      if (lap_end) begin
        // A load landing on the wrap edge bypasses the shadow entirely.
        upd_pend_d = 1'b0;
        if (load)            disp_word_d = data_in;
        else if (upd_pend_q) disp_word_d = shadow_q;
      end else if (load) begin
        shadow_d   = data_in;
        upd_pend_d = 1'b1;
      end
    end
  end

  // Pick the nibble (or dash) for the digit currently being scanned.
  always_comb begin
    p       = 0;
    nib_i   = 0;
    dash    = 1'b0;
    word_sh = '0;
    nib     = '0;
    if (scroll_en) begin
      p = int'(pos_q) + (DIGITS - 1) - int'(digit_idx_q);
      if (p >= L) p = p - L;
      if (p < NIB) nib_i = NIB - 1 - p;
      else         dash  = 1'b1;
    end else begin
      nib_i = int'(digit_idx_q);
    end
    word_sh = disp_word_q >> (4 * nib_i);
    nib     = word_sh[3:0];
    sel_d   = ~(DIGITS'(1) << digit_idx_q);
    seg_d   = (!en || dash) ? 8'hFD : hex2seg(nib);
  end

  // State and output registers; sel/seg load on the same edge so they agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_q   <= '0;
      digit_idx_q <= '0;
      scr_cnt_q   <= '0;
      pos_q       <= '0;
      disp_word_q <= '0;
      shadow_q    <= '0;
      upd_pend_q  <= 1'b0;
      wrap_q      <= 1'b0;
      sel_q       <= '1;
      seg_q       <= 8'hFF;
    end else begin
      ref_cnt_q   <= ref_cnt_d;
      digit_idx_q <= digit_idx_d;
      scr_cnt_q   <= scr_cnt_d;
      pos_q       <= pos_d;
      disp_word_q <= disp_word_d;
      shadow_q    <= shadow_d;
      upd_pend_q  <= upd_pend_d;
      wrap_q      <= wrap_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
    end
  end

  assign sel        = sel_q;
  assign seg        = seg_q;
  assign upd_pend   = upd_pend_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_seg_scroll_disp.sv
// Bench for seg_scroll_disp: reference model driven by elapsed-cycle arithmetic,
// a static decode table, directed scroll/reset sequences and random traffic.
module tb_seg_scroll_disp;

  localparam int DIGITS = 4;
  localparam int DATA_W = 16;
  localparam int RD     = 4;
  localparam int SD     = 16;
  localparam int GAP    = 2;
  localparam int NIB    = DATA_W / 4;
  localparam int L      = NIB + GAP;
  localparam int LAP    = SD * L;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              load = 1'b0;
  logic              en = 1'b1;
  logic              scroll_en = 1'b0;
  logic [DIGITS-1:0] sel;
  logic [7:0]        seg;
  logic              upd_pend;
  logic              wrap_pulse;

  seg_scroll_disp #(
    .DIGITS(DIGITS), .DATA_W(DATA_W), .REFRESH_DIV(RD), .SCROLL_DIV(SD), .GAP(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .en(en),
    .scroll_en(scroll_en), .sel(sel), .seg(seg), .upd_pend(upd_pend),
    .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [7:0] dec_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  // Segment pattern for one digit, straight from the stream definition.
  function automatic logic [7:0] ref_seg(input int digit, input int posv,
                                         input logic [15:0] w, input logic e, input logic sc);
    int st [L];
    int idx;
    logic [15:0] sh;
    if (!e) return 8'hFD;
    if (!sc) begin
      sh = w >> (4 * digit);
      return dec_tab[sh[3:0]];
    end
    for (int q = 0; q < L; q++) st[q] = (q < NIB) ? (NIB - 1 - q) : -1;
    idx = (posv + DIGITS - 1 - digit) % L;
    if (st[idx] < 0) return 8'hFD;
    sh = w >> (4 * st[idx]);
    return dec_tab[sh[3:0]];
  endfunction

  function automatic bit at_lap_end(input int s);
    return ((s + 1) % LAP) == 0;
  endfunction

  // Model state: cycles since reset (refresh) and cycles since scroll start.
  int          m_t, m_s;
  logic [15:0] m_word, m_shadow;
  logic        m_pend;
  logic [3:0]  e_sel;
  logic [7:0]  e_seg;
  logic        e_wrap, e_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_s <= 0; m_word <= '0; m_shadow <= '0; m_pend <= 1'b0;
      e_sel <= 4'hF; e_seg <= 8'hFF; e_wrap <= 1'b0; e_pend <= 1'b0;
    end else begin
      e_sel  <= ~(4'b0001 << ((m_t / RD) % DIGITS));
      e_seg  <= ref_seg((m_t / RD) % DIGITS, (m_s / SD) % L, m_word, en, scroll_en);
      e_wrap <= scroll_en && at_lap_end(m_s);
      e_pend <= scroll_en && !at_lap_end(m_s) && (load || m_pend);
      m_t    <= (m_t + 1) % (RD * DIGITS);
      if (!scroll_en || at_lap_end(m_s)) begin
        m_s    <= 0;
        m_pend <= 1'b0;
        if (load)        m_word <= data_in;
        else if (m_pend) m_word <= m_shadow;
      end else begin
        m_s <= m_s + 1;
        if (load) begin
          m_shadow <= data_in;
          m_pend   <= 1'b1;
        end
      end
    end
  end

  bit chk_on = 1'b0;
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_sel", 32'(sel), 32'(e_sel));
      check("model_seg", 32'(seg), 32'(e_seg));
      check("model_pend", 32'(upd_pend), 32'(e_pend));
      check("model_wrap", 32'(wrap_pulse), 32'(e_wrap));
    end
  end

  logic [7:0] cap [DIGITS];
  logic [3:0] cap_mask;

  // Record what each digit shows over n cycles.
  task automatic capture(input int n);
    cap_mask = '0;
    repeat (n) begin
      @(negedge clk);
      for (int k = 0; k < DIGITS; k++) begin
        if (sel == ~(4'b0001 << k)) begin
          cap[k] = seg;
          cap_mask[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_digits(input string name, input logic [7:0] d3, input logic [7:0] d2,
                              input logic [7:0] d1, input logic [7:0] d0);
    check({name, "_seen"}, 32'(cap_mask), 32'hF);
    check({name, "_d3"}, 32'(cap[3]), 32'(d3));
    check({name, "_d2"}, 32'(cap[2]), 32'(d2));
    check({name, "_d1"}, 32'(cap[1]), 32'(d1));
    check({name, "_d0"}, 32'(cap[0]), 32'(d0));
  endtask

  // Count negedges until wrap_pulse is seen, bounded.
  task automatic wait_wrap(output int cnt, output bit found);
    found = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cnt++;
      if (wrap_pulse) begin
        found = 1'b1;
        return;
      end
    end
  endtask

  typedef struct {
    logic [15:0] word;
    int          digit;
    logic [7:0]  seg;
  } vec_t;

  vec_t tbl [10];
  logic [3:0] want;
  bit found;
  int cnt;
  bit last_pend;

  initial begin
    tbl[0] = '{16'h1234, 0, 8'h99};
    tbl[1] = '{16'h1234, 3, 8'h9F};
    tbl[2] = '{16'h1234, 1, 8'h0D};
    tbl[3] = '{16'h1234, 2, 8'h25};
    tbl[4] = '{16'hABCD, 0, 8'h85};
    tbl[5] = '{16'hABCD, 3, 8'h11};
    tbl[6] = '{16'hF0E8, 0, 8'h01};
    tbl[7] = '{16'hF0E8, 1, 8'h61};
    tbl[8] = '{16'hF0E8, 2, 8'h03};
    tbl[9] = '{16'hF0E8, 3, 8'h71};

    // Reset state
    #12;
    check("rst_sel", 32'(sel), 32'hF);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_pend", 32'(upd_pend), 32'h0);
    check("rst_wrap", 32'(wrap_pulse), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    check("rel_sel_first", 32'(sel), 32'hE);
    repeat (4) @(negedge clk);
    check("rel_sel_step", 32'(sel), 32'hD);

    // Static decode table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      data_in = tbl[i].word;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      want = ~(4'b0001 << tbl[i].digit);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        @(negedge clk);
        if (sel == want) found = 1'b1;
      end
      check("tbl_sel_found", 32'(found), 32'h1);
      check("tbl_seg", 32'(seg), 32'(tbl[i].seg));
      check("tbl_pend", 32'(upd_pend), 32'h0);
    end

    // Scroll 1234: position 1 shows 2,3,4,-
    @(negedge clk);
    data_in = 16'h1234;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    scroll_en = 1'b1;
    repeat (16) @(negedge clk);
    capture(16);
    check_digits("scr_pos1", 8'h25, 8'h0D, 8'h99, 8'hFD);
    wait_wrap(cnt, found);
    check("wrap1_found", 32'(found), 32'h1);
    wait_wrap(cnt, found);
    check("wrap_period", 32'(cnt), 32'(LAP));

    // Load ABCD at position 2; 1234 holds until the lap wraps
    repeat (33) @(negedge clk);
    data_in = 16'hABCD;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    data_in = 16'h0000;
    check("shadow_pend", 32'(upd_pend), 32'h1);
    last_pend = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (wrap_pulse) found = 1'b1;
      else            last_pend = upd_pend;
    end
    check("shadow_wrap_found", 32'(found), 32'h1);
    check("shadow_pend_held", 32'(last_pend), 32'h1);
    check("shadow_pend_clr", 32'(upd_pend), 32'h0);
    capture(16);
    check_digits("shadow_pos0", 8'h11, 8'hC1, 8'h63, 8'h85);

    // en=0 blanks to dashes while scanning continues
    @(negedge clk);
    scroll_en = 1'b0;
    data_in = 16'h1234;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    en = 1'b0;
    capture(16);
    check_digits("en0", 8'hFD, 8'hFD, 8'hFD, 8'hFD);
    en = 1'b1;
    capture(16);
    check_digits("en1", 8'h9F, 8'h25, 8'h0D, 8'h99);

    // Async reset at position 3 with a pending word
    @(negedge clk);
    scroll_en = 1'b1;
    repeat (40) @(negedge clk);
    data_in = 16'h5555;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("mid_pend", 32'(upd_pend), 32'h1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sel", 32'(sel), 32'hF);
    check("mid_rst_seg", 32'(seg), 32'hFF);
    check("mid_rst_pend", 32'(upd_pend), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    capture(16);
    check_digits("post_rst", 8'h03, 8'h03, 8'h03, 8'h03);
    check("post_rst_pend", 32'(upd_pend), 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      load = ($urandom_range(7) == 0);
      data_in = 16'($urandom);
      if ($urandom_range(63) == 0)  en = ~en;
      if ($urandom_range(199) == 0) scroll_en = ~scroll_en;
    end
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
